// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 binary to packed BCD converter, WIDTH cycles per result.
// Optional macro BIN2BCD_LZB_EN adds the leading-zero blanking output. Revision 1.0.
`default_nettype none

module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
`ifdef BIN2BCD_LZB_EN
  ,
  output logic [DIGITS-1:0]     blank
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_busy;
  logic            w_accept;
  logic            w_last;

  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]    r_acc;
  logic             r_sticky;
  logic [CW-1:0]    r_cnt;
  logic [BW-1:0]    r_bcd;
  logic             r_ovf;
  logic             r_done;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_acc_next;
  logic             w_ovf_next;
  logic [BW-1:0]    w_bcd_final;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_busy = 1'b1;
        if (r_cnt == C_LAST) begin
          w_last       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Per-nibble add-3 with no inter-nibble carry; a nibble of 5..9 becomes 8..12 and never wraps.
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3)
                                                       : r_acc[4*i +: 4];
  end

  assign w_acc_next  = {w_adj[BW-2:0], r_bin[WIDTH-1]};
  assign w_ovf_next  = r_sticky | w_adj[BW-1];
  assign w_bcd_final = w_ovf_next ? {DIGITS{4'h9}} : w_acc_next;

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;

  assign w_blank_next[0] = 1'b0;
  for (genvar i = 1; i < DIGITS; i++) begin : g_blank
    assign w_blank_next[i] = ~w_ovf_next & (w_acc_next[BW-1:4*i] == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blank <= '0;
    end else if (w_last) begin
      r_blank <= w_blank_next;
    end
  end

  assign blank = r_blank;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin    <= '0;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_cnt    <= '0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_bin    <= bin;
        r_acc    <= '0;
        r_sticky <= 1'b0;
        r_cnt    <= '0;
      end else if (w_busy) begin
        r_bin    <= {r_bin[WIDTH-2:0], 1'b0};
        r_acc    <= w_acc_next;
        r_sticky <= w_ovf_next;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_bcd  <= w_bcd_final;
          r_ovf  <= w_ovf_next;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = w_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ovf  = r_ovf;

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
- Sits directly upstream of the decimal 7-segment decoders: its packed BCD output feeds the two-digit decimal decoder, one nibble per digit.
- Converts a WIDTH-bit unsigned value into DIGITS packed BCD nibbles in WIDTH clock cycles.
- Uses a start/busy/done handshake, so one small datapath serves counters, ADC readings and similar sources.

Parameters:
- WIDTH, 8, bit width of the binary input (2..32).
- DIGITS, 3, number of BCD output digits (1..10).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin  input  WIDTH  unsigned value; latched on the accepted start edge.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/ovf are updated.
- bcd  output  4*DIGITS  packed result; [3:0] is units, [7:4] tens, and so on; holds its value between conversions.
- ovf  output  1  result did not fit in DIGITS digits; held with bcd.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, busy=0, done=0, bcd=0, ovf=0, shift counter=0, internal shift register cleared. Reset takes priority over everything, including mid-conversion; the partial result is discarded.
- States:
  - IDLE: busy=0. If start=1 at an edge, latch bin into the binary shift register, clear the BCD accumulator and the overflow sticky, set counter=0, and go to SHIFT.
  - SHIFT: busy=1. On each edge, first every accumulator nibble >=5 gets +3. Then the whole {accumulator, binary} register shifts left by 1. If a 1 is shifted out of the top nibble's MSB, set the overflow sticky.
  - SHIFT exit: after the WIDTH-th shift edge, go to IDLE. On that same edge update bcd and ovf and set done=1 for exactly one cycle.
- Latency: start accepted at edge k; busy=1 during cycles k+1..k+WIDTH; done=1, busy=0 and the new bcd are visible after edge k+WIDTH.
- start while busy=1 is ignored. It is not queued, and bin changes are ignored after latch.
- start=1 in the done cycle is accepted, so back-to-back throughput is one conversion per WIDTH+1 cycles.
- Overflow: if the sticky is set at completion, ovf=1 and bcd saturates to all nibbles 4'h9. Otherwise ovf=0 and bcd is the exact conversion.
- Every bcd nibble is always within 0..9 and never takes A..F, so downstream decimal decoders never see illegal codes.
- The nibble adjust uses a 4-bit add with no carry between nibbles; the add-3 rule guarantees no nibble wrap.
- The counter is $clog2(WIDTH+1) bits wide and never wraps past WIDTH.

Optional Feature:
- Macro: BIN2BCD_LZB_EN (leading-zero blanking).
- Defined:
  - Adds output port blank, DIGITS bits wide, bit i for digit i.
  - blank[i]=1 when digit i and every more-significant digit are 0. blank[0] is always 0, so a value of 0 shows a single "0".
  - blank is updated on the same edge as bcd, reset to 0, and all zeros when ovf=1.
- Not defined: no blank port; behaviour is otherwise identical.

Test Plan:
- Reset then idle, WIDTH=8, DIGITS=3: bcd=12'h000, ovf=0, busy=0, done=0; start=0 for 20 cycles -> no change.
- bin=8'd255, start pulse -> busy high for exactly 8 cycles, then done one cycle, bcd=12'h255, ovf=0. With LZB: blank=3'b000.
- bin=8'd7, then a second start with bin=8'd200 asserted mid-conversion -> second start ignored, bcd=12'h007. With LZB: blank=3'b110.
- DIGITS=2: bin=8'd99 -> bcd=8'h99, ovf=0. bin=8'd100 -> bcd=8'h99, ovf=1. bin=8'd0 -> bcd=8'h00, ovf=0.
- Back-to-back: start held high continuously with bin=8'd42 then 8'd128 -> done pulses every 9 cycles, bcd=12'h042 then 12'h128.
- rst=1 at cycle 4 of a conversion of 8'd255 -> next cycle busy=0, bcd=0, no done pulse. A new start converts correctly.
- Exhaustive: all 256 inputs at WIDTH=8, DIGITS=3 compared against a software model; every nibble is <=9.
